dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-back, write-allocate data-cache controller between the pipeline MEM stage and
//  Data_Memory. Serves hits in the same cycle. On a miss it freezes the pipeline (stall_o) and sequences
//  an optional dirty-line writeback, then a line refill, over a req/ack handshake to the memory.
// PARAMETERS
//  ADDR_W    32   byte-address width
//  LINE_W    256  cache line width in bits (8 words); OFFSET_W = log2(LINE_W/8)
//  INDEX_W   5    index bits; 32 lines; TAG_W = ADDR_W-INDEX_W-OFFSET_W
// PORTS
//  clk_i        in   1        clock
//  rst_i        in   1        synchronous reset, active-high
//  cpu_req_i    in   1        MEM-stage access valid (Memread | Memwrite)
//  cpu_we_i     in   1        1 = store word, 0 = load word
//  cpu_addr_i   in   ADDR_W   byte address; bits [1:0] ignored
//  cpu_wdata_i  in   32       store data
//  cpu_rdata_o  out  32       load data, valid when cpu_req_i & !cpu_we_i & !stall_o
//  stall_o      out  1        freeze PC/IF/ID/EX/MEM latches
//  mem_req_o    out  1        memory request, held until mem_ack_i
//  mem_we_o     out  1        1 = line writeback, 0 = line fetch
//  mem_addr_o   out  ADDR_W   line-aligned address (offset bits = 0)
//  mem_wdata_o  out  LINE_W   victim line for writeback
//  mem_rdata_i  in   LINE_W   fetched line, valid with mem_ack_i
//  mem_ack_i    in   1        one-cycle completion pulse
// BEHAVIOUR
//  - Reset: FSM=IDLE; all valid/dirty bits=0; stall_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, cpu_rdata_o=0.
//  - hit = cpu_req_i & valid[idx] & (tag[idx]==addr tag). Combinational decode; word select = addr[OFFSET_W-1:2].
//  - IDLE, hit: stall_o=0. Load: cpu_rdata_o = selected word in the same cycle.
//    Store: selected word is written on the posedge and dirty[idx] is set to 1.
//  - IDLE, miss: stall_o=1 in the same cycle, combinationally.
//    Next state is WRITEBACK if valid&dirty of the victim, else REFILL.
//  - WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag,idx,0}, mem_wdata_o=victim line.
//    On mem_ack_i go to REFILL.
//  - REFILL: mem_req_o=1, mem_we_o=0, mem_addr_o={cpu tag,idx,0}. On mem_ack_i:
//    line<=mem_rdata_i, tag<=cpu tag, valid<=1, dirty<=0; go to IDLE.
//    The replayed access then hits (stores merge and set dirty).
//  - stall_o=1 throughout WRITEBACK and REFILL, and in the IDLE cycle of a miss.
//  - Latency: clean miss = 1 + refill ack wait + 1 replay cycle. Dirty miss adds the writeback ack wait.
//  - Pipeline holds cpu_* stable while stall_o=1; the controller does not re-sample them mid-miss.
//  - mem_req_o deasserts the cycle after ack, unless REFILL immediately follows WRITEBACK.
//    Req stays high across that transition, with address and we changing.
//  - mem_ack_i while mem_req_o=0 is ignored.
//  - cpu_req_i=0: no state change, stall_o=0.
//  - rst_i mid-miss: abort to IDLE, drop mem_req_o next edge, invalidate all lines. Dirty data is discarded.
// CONFIGURATION
//  DCACHE_STATS_EN defined:
//   - adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], both cleared by rst_i.
//   - hit_cnt_o increments on each IDLE-state access that hits with stall_o=0 (replays count as hits).
//   - miss_cnt_o increments once per IDLE-to-WRITEBACK/REFILL transition.
//  Undefined: these ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  - dcache_pkg: state enum {IDLE, WRITEBACK, REFILL}, OFFSET_W/TAG_W localparams,
//    and functions for address field extraction and line/word merge.
//  - Sub-module dcache_sram: tag/valid/dirty/data arrays.
//    Async read, sync write, with separate ports for full-line refill and word write.
//  - dcache_ctrl holds the FSM, hit logic and the memory handshake.
// TESTING
//  1 Cold load 0x00 with memory line = {...,word0=5}:
//    stall_o=1 until ack, then 0; cpu_rdata_o=5; miss_cnt_o=1.
//  2 Store 0x04 <- 7 after test 1: hit, no stall, dirty[0]=1.
//    Load 0x04 -> 7; hit_cnt_o increments by 2.
//  3 Load 0x400 (same index 0, new tag): WRITEBACK with mem_addr_o=0x00 and word1=7 in mem_wdata_o,
//    then REFILL with mem_addr_o=0x400; req stays high across the transition.
//  4 Conflict on a clean line: load 0x20 then 0x420. No writeback; mem_we_o stays 0.
//  5 Ack delayed 10 cycles: mem_req_o, mem_addr_o and stall_o stay stable for all 10.
//    A spurious ack while idle causes no state change.
//  6 rst_i asserted during REFILL: next cycle IDLE, mem_req_o=0, stall_o=0.
//    A load to the same address misses again.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache controller: geometry, FSM state
// encoding and helpers for splitting byte addresses and editing lines.
//
// Geometry: 32-bit byte address, 256-bit lines (8 words), 32 lines.
//   addr = { tag[21:0], index[4:0], word_sel[2:0], byte[1:0] }
package dcache_pkg;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 256;
  localparam int INDEX_W  = 5;
  localparam int WORD_W   = 32;
  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam int WSEL_W   = OFFSET_W - 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;

  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [INDEX_W-1:0] idx_t;
  typedef logic [WSEL_W-1:0]  wsel_t;
  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_e;

  function automatic tag_t addr_tag(input addr_t addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic idx_t addr_idx(input addr_t addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic wsel_t addr_wsel(input addr_t addr);
    return addr[2 +: WSEL_W];
  endfunction

  function automatic addr_t line_addr(input tag_t tag, input idx_t idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction

  function automatic word_t line_word(input line_t line, input wsel_t wsel);
    return line[wsel*WORD_W +: WORD_W];
  endfunction

  function automatic line_t line_merge(input line_t line, input wsel_t wsel,
                                       input word_t data);
    line_t merged;
    merged = line;
    merged[wsel*WORD_W +: WORD_W] = data;
    return merged;
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag / valid / dirty / data storage for the direct-mapped cache.
// Asynchronous read of the entry selected by idx_i; synchronous writes
// through two ports: a full-line refill and a single-word store.
// Refill wins if both are requested in the same cycle.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (clears valid/dirty)
//   idx_i               line index for both read and write
//   rd_tag_o/valid/dirty/line_o   current contents of the indexed entry
//   refill_en_i, refill_tag_i, refill_line_i   install a fetched line (valid=1, dirty=0)
//   wr_en_i, wr_wsel_i, wr_data_i              store one word (dirty=1)
module dcache_sram
  import dcache_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  idx_t  idx_i,
  output tag_t  rd_tag_o,
  output logic  rd_valid_o,
  output logic  rd_dirty_o,
  output line_t rd_line_o,
  input  logic  refill_en_i,
  input  tag_t  refill_tag_i,
  input  line_t refill_line_i,
  input  logic  wr_en_i,
  input  wsel_t wr_wsel_i,
  input  word_t wr_data_i
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  tag_t             tag_q  [LINES];
  line_t            data_q [LINES];

  assign rd_tag_o   = tag_q[idx_i];
  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_line_o  = data_q[idx_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (refill_en_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk_i) begin
    if (refill_en_i) begin
      tag_q[idx_i]  <= refill_tag_i;
      data_q[idx_i] <= refill_line_i;
    end else if (wr_en_i) begin
      data_q[idx_i] <= line_merge(data_q[idx_i], wr_wsel_i, wr_data_i);
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller between
// the MEM stage and data memory. Hits complete in the same cycle; a miss
// raises stall_o combinationally, optionally writes back the dirty victim,
// refills the line and then replays the held access as a hit.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i   MEM-stage access (held while stall_o=1)
//   cpu_rdata_o               load data, valid on an unstalled load
//   stall_o                   pipeline freeze
//   mem_req_o/we_o/addr_o/wdata_o   line request to memory, held until ack
//   mem_rdata_i, mem_ack_i    fetched line and one-cycle completion pulse
//   hit_cnt_o, miss_cnt_o     access statistics (only with DCACHE_STATS_EN)
//
// Build option: define DCACHE_STATS_EN to add the hit/miss counters.
//
// state     | meaning
// IDLE      | serve hits; on a miss stall and pick WRITEBACK or REFILL
// WRITEBACK | write dirty victim line to memory, wait for ack
// REFILL    | fetch requested line, install it on ack, return to IDLE
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  state_e state_q, state_d;

  tag_t  cpu_tag;
  idx_t  cpu_idx;
  wsel_t cpu_wsel;

  tag_t  rd_tag;
  logic  rd_valid;
  logic  rd_dirty;
  line_t rd_line;

  logic  hit;
  logic  refill_en;
  logic  wr_en;

  assign cpu_tag  = addr_tag(cpu_addr_i);
  assign cpu_idx  = addr_idx(cpu_addr_i);
  assign cpu_wsel = addr_wsel(cpu_addr_i);

  dcache_sram u_sram (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .idx_i         (cpu_idx),
    .rd_tag_o      (rd_tag),
    .rd_valid_o    (rd_valid),
    .rd_dirty_o    (rd_dirty),
    .rd_line_o     (rd_line),
    .refill_en_i   (refill_en),
    .refill_tag_i  (cpu_tag),
    .refill_line_i (mem_rdata_i),
    .wr_en_i       (wr_en),
    .wr_wsel_i     (cpu_wsel),
    .wr_data_i     (cpu_wdata_i)
  );

  assign hit = cpu_req_i & rd_valid & (rd_tag == cpu_tag);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The cpu_* inputs are frozen by the stall, so the SRAM read port keeps
  // presenting the victim entry throughout WRITEBACK.
  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    refill_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req_i && !hit) begin
          stall_o = 1'b1;
          state_d = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = line_addr(rd_tag, cpu_idx);
        mem_wdata_o = rd_line;
        if (mem_ack_i) begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = line_addr(cpu_tag, cpu_idx);
        if (mem_ack_i) begin
          refill_en = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wr_en       = (state_q == IDLE) && hit && cpu_we_i;
  assign cpu_rdata_o = ((state_q == IDLE) && hit && !cpu_we_i)
                       ? line_word(rd_line, cpu_wsel) : '0;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if ((state_q == IDLE) && hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if ((state_q == IDLE) && cpu_req_i && !hit) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         stall;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: cache directory (which lines are resident and dirty),
  // backing memory contents, and stores still living only in the cache.
  bit           m_valid [32];
  logic [21:0]  m_tag   [32];
  bit           m_dirty [32];
  logic [255:0] bmem [logic [31:0]];
  logic [31:0]  pend [logic [31:0]];
  int           exp_hits;
  int           exp_misses;

  dcache_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rdata_o (cpu_rdata),
    .stall_o     (stall),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0]  b;
    logic [255:0] l;
    b = {a[31:5], 5'b0};
    if (bmem.exists(b)) begin
      l = bmem[b];
      return l[a[4:2]*32 +: 32];
    end
    return 32'd5 + 32'd3 * a;
  endfunction

  function automatic logic [31:0] arch_word(input logic [31:0] a);
    if (pend.exists(a)) return pend[a];
    return mem_word(a);
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = arch_word(base + 32'(w * 4));
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = mem_word(base + 32'(w * 4));
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    pend.delete();
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // One CPU access held until the cache stops stalling; the bench plays the
  // memory, acking each request after 'delay' extra cycles.
  task automatic do_access(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int delay);
    logic [4:0]   idx;
    logic [21:0]  tg;
    logic [31:0]  a;
    logic [31:0]  victim;
    logic [255:0] exp_wbline;
    logic [31:0]  exp_rd;
    logic [31:0]  ph_addr;
    bit           exp_hit, exp_wb, saw_wb, prev_ack_wb, ph_on;
    int           exp_stall, stall_n, wait_n, guard;

    a      = {addr[31:2], 2'b00};
    idx    = a[9:5];
    tg     = a[31:10];
    victim = {m_tag[idx], idx, 5'b0};
    exp_hit    = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb     = !exp_hit && m_valid[idx] && m_dirty[idx];
    exp_wbline = exp_line(victim);
    exp_rd     = arch_word(a);
    exp_stall  = exp_hit ? 0 : (exp_wb ? 3 + 2 * delay : 2 + delay);

    @(negedge clk);
`ifdef DCACHE_STATS_EN
    checks++;
    if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses))
      $display("FAIL stats: hit_cnt=%0d miss_cnt=%0d expected %0d/%0d",
               hit_cnt, miss_cnt, exp_hits, exp_misses);
    if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) errors++;
`endif
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    #1;

    stall_n = 0; wait_n = 0; guard = 0;
    saw_wb = 0; prev_ack_wb = 0; ph_on = 0; ph_addr = '0;
    while (stall === 1'b1 && guard < 300) begin
      stall_n++;
      if (prev_ack_wb) begin
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== {tg, idx, 5'b0}) begin
          errors++;
          $display("FAIL wb_to_refill: req=%b we=%b addr=%h expected 1/0/%h",
                   mem_req, mem_we, mem_addr, {tg, idx, 5'b0});
        end
      end
      prev_ack_wb = 0;
      if (mem_req === 1'b1) begin
        if (!ph_on) begin
          ph_on = 1; ph_addr = mem_addr;
        end else begin
          checks++;
          if (mem_addr !== ph_addr) begin
            errors++;
            $display("FAIL addr_stable: addr=%h expected %h", mem_addr, ph_addr);
          end
        end
        if (mem_we === 1'b1) saw_wb = 1;
        if (wait_n == delay) begin
          if (mem_we === 1'b1) begin
            checks++;
            if (mem_addr !== victim || mem_wdata !== exp_wbline) begin
              errors++;
              $display("FAIL writeback: addr=%h data=%h expected %h data=%h",
                       mem_addr, mem_wdata, victim, exp_wbline);
            end
            bmem[victim] = exp_wbline;
            for (int w = 0; w < 8; w++) pend.delete(victim + 32'(w * 4));
            prev_ack_wb = 1;
          end else begin
            mem_rdata = mem_line({mem_addr[31:5], 5'b0});
          end
          mem_ack = 1'b1;
          wait_n  = 0;
          ph_on   = 0;
        end else begin
          wait_n++;
        end
      end
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      guard++;
    end

    checks++;
    if (guard >= 300) begin
      errors++;
      $display("FAIL timeout: still stalled after %0d cycles at addr %h", guard, addr);
    end
    checks++;
    if (stall_n != exp_stall) begin
      errors++;
      $display("FAIL latency: addr=%h stall cycles=%0d expected %0d", addr, stall_n, exp_stall);
    end
    checks++;
    if (saw_wb != exp_wb) begin
      errors++;
      $display("FAIL wb_seen: addr=%h writeback=%0d expected %0d", addr, saw_wb, exp_wb);
    end
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL req_drop: mem_req=%b expected 0 after completion", mem_req);
    end
    if (!we) begin
      checks++;
      if (cpu_rdata !== exp_rd) begin
        errors++;
        $display("FAIL load_data: addr=%h rdata=%h expected %h", addr, cpu_rdata, exp_rd);
      end
    end

    if (!exp_hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
      exp_misses++;
    end
    exp_hits++;
    if (we) begin
      pend[a]      = wdata;
      m_dirty[idx] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== 32'h0 || cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b req=%b we=%b addr=%h rdata=%h expected all 0",
               stall, mem_req, mem_we, mem_addr, cpu_rdata);
    end
  endtask

  task automatic test_cold_load();
    do_access(1'b0, 32'h0000_0000, 32'h0, 0);
  endtask

  task automatic test_store_hit();
    do_access(1'b1, 32'h0000_0004, 32'h7, 0);
    do_access(1'b0, 32'h0000_0004, 32'h0, 0);
  endtask

  task automatic test_dirty_evict();
    do_access(1'b0, 32'h0000_0400, 32'h0, 1);
  endtask

  task automatic test_clean_conflict();
    do_access(1'b0, 32'h0000_0020, 32'h0, 0);
    do_access(1'b0, 32'h0000_0420, 32'h0, 0);
  endtask

  task automatic test_delayed_ack();
    do_access(1'b0, 32'h0000_1000, 32'h0, 10);
    do_access(1'b1, 32'h0000_1044, 32'hDEAD_BEEF, 10);
    do_access(1'b0, 32'h0000_2044, 32'h0, 10);
    do_access(1'b1, 32'h0000_2048, 32'h1234_5678, 0);
  endtask

  task automatic test_spurious_ack();
    @(negedge clk);
    cpu_req = 1'b0;
    mem_ack = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_noreq: stall=%b req=%b expected 0/0", stall, mem_req);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL spurious_ack: stall=%b req=%b expected 0/0", stall, mem_req);
    end
    do_access(1'b0, 32'h0000_2048, 32'h0, 0);
  endtask

  task automatic test_reset_mid_miss();
    int n;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_30E0;
    n = 0;
    #1;
    while (!(mem_req === 1'b1 && mem_we === 1'b0) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL refill_start: mem_req=%b we=%b expected 1/0", mem_req, mem_we);
    end
    @(negedge clk);
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: req=%b stall=%b expected 0/0", mem_req, stall);
    end
    rst = 1'b0;
    model_reset();
    do_access(1'b0, 32'h0000_30E0, 32'h0, 2);
    do_access(1'b0, 32'h0000_2048, 32'h0, 0);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int i = 0; i < 80; i++) begin
      addr = {20'h0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              3'($urandom_range(0, 7)), 2'b00};
      do_access(1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      do_access(1'b1, 32'h0000_0060 + 32'(i * 4), 32'hA000_0000 + 32'(i), 0);
    end
    for (int i = 0; i < 8; i++) begin
      do_access(1'b0, 32'h0000_0060 + 32'(i * 4), 32'h0, 0);
    end
    do_access(1'b0, 32'h0000_0860, 32'h0, 1);
    do_access(1'b0, 32'h0000_0064, 32'h0, 0);
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_dirty_evict();
    test_clean_conflict();
    test_delayed_ack();
    test_spurious_ack();
    test_reset_mid_miss();
    test_back_to_back();
    test_random();
    @(negedge clk);
    cpu_req = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
